// File: rtl/sram_multiport_param.sv
// Parametrised multi-port synchronous SRAM with byte-lane writes, lowest-port-wins
// lane priority, saturating collision counter, optional read-during-write bypass and a post-reset clear sweep.
module sram_multiport_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WR     = 2,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1
) (
  input  logic                           Clk_In,
  input  logic                           Reset_In,
  output logic                           Ready_Out,
  input  logic [NUM_WR-1:0]              Wr_En_In,
  input  logic [NUM_WR*ADDR_WIDTH-1:0]   Wr_Addr_In,
  input  logic [NUM_WR*DATA_WIDTH-1:0]   Wr_Data_In,
  input  logic [NUM_WR*DATA_WIDTH/8-1:0] Wr_Byte_En_In,
  input  logic [NUM_RD-1:0]              Rd_En_In,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   Rd_Addr_In,
  output logic [NUM_RD*DATA_WIDTH-1:0]   Rd_Data_Out,
  output logic [NUM_RD-1:0]              Rd_Valid_Out,
  output logic                           Collision_Out,
  output logic [15:0]                    Collision_Count_Out
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LANES = DATA_WIDTH / 8;

  typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   sweep;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   wr_addr [NUM_WR];
  logic [DATA_WIDTH-1:0]   wr_data [NUM_WR];
  logic [ADDR_WIDTH-1:0]   rd_addr [NUM_RD];
  logic [DATA_WIDTH-1:0]   rd_word [NUM_RD];
  logic [NUM_WR-1:0][LANES-1:0] win;
  logic                    lane_req;
  logic                    lane_blocked;
  logic                    collision;

  always_ff @(posedge Clk_In) begin
    if (!Reset_In) state <= INIT;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == INIT && sweep == {ADDR_WIDTH{1'b1}}) state_next = READY;
  end

  assign Ready_Out = (state == READY);

  always_comb begin
    for (int p = 0; p < NUM_WR; p++) begin
      wr_addr[p] = Wr_Addr_In[p*ADDR_WIDTH +: ADDR_WIDTH];
      wr_data[p] = Wr_Data_In[p*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int r = 0; r < NUM_RD; r++) rd_addr[r] = Rd_Addr_In[r*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // A lane is lost when any lower-index port claims the same address and lane.
  always_comb begin
    win          = '0;
    collision    = 1'b0;
    lane_req     = 1'b0;
    lane_blocked = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      for (int b = 0; b < LANES; b++) begin
        lane_req     = Wr_En_In[p] && Wr_Byte_En_In[p*LANES + b] && (state == READY);
        lane_blocked = 1'b0;
        for (int q = 0; q < p; q++) begin
          if (Wr_En_In[q] && Wr_Byte_En_In[q*LANES + b] && wr_addr[q] == wr_addr[p])
            lane_blocked = 1'b1;
        end
        win[p][b] = lane_req && !lane_blocked;
        if (lane_req && lane_blocked) collision = 1'b1;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      rd_word[r] = mem[rd_addr[r]];
      if (BYPASS != 0) begin
        for (int p = 0; p < NUM_WR; p++) begin
          for (int b = 0; b < LANES; b++) begin
            if (win[p][b] && wr_addr[p] == rd_addr[r]) rd_word[r][8*b +: 8] = wr_data[p][8*b +: 8];
          end
        end
      end
    end
  end

  // Winners are unique per (address, lane), so the lane writes never overlap.
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      if (state == INIT) begin
        mem[sweep] <= '0;
      end else begin
        for (int p = 0; p < NUM_WR; p++) begin
          for (int b = 0; b < LANES; b++) begin
            if (win[p][b]) mem[wr_addr[p]][8*b +: 8] <= wr_data[p][8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge Clk_In) begin
    if (!Reset_In) begin
      sweep               <= '0;
      Rd_Data_Out         <= '0;
      Rd_Valid_Out        <= '0;
      Collision_Out       <= 1'b0;
      Collision_Count_Out <= '0;
    end else begin
      if (state == INIT) sweep <= sweep + 1'b1;
      for (int r = 0; r < NUM_RD; r++) begin
        if (state == READY && Rd_En_In[r]) begin
          Rd_Data_Out[r*DATA_WIDTH +: DATA_WIDTH] <= rd_word[r];
          Rd_Valid_Out[r]                         <= 1'b1;
        end else begin
          Rd_Valid_Out[r] <= 1'b0;
        end
      end
      Collision_Out <= collision;
      if (collision && Collision_Count_Out != 16'hFFFF)
        Collision_Count_Out <= Collision_Count_Out + 16'd1;
    end
  end
endmodule
